uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

UART transmit controller that takes one parallel byte on a valid strobe and sequences a complete serial frame on TX_OUT: start bit, data bits LSB first, optional parity bit, stop bit. It sits between the TX-side data source and the serial line. It owns the frame state machine, data shift register, bit counter, parity generation and output-bit selection. CLK is the bit-rate clock, so one frame bit is sent per CLK cycle.

## Interface
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..8)
- CLK  input  1  bit-rate clock, rising-edge
- RST  input  1  reset, asynchronous, active-low
- P_DATA  input  DATA_WIDTH  parallel data to send
- Data_Valid  input  1  request strobe; accepted only while busy=0
- PAR_EN  input  1  1: insert parity bit; sampled at accept
- PAR_TYP  input  1  0: even parity, 1: odd parity; sampled at accept
- TX_OUT  output  1  serial line, registered, idle high
- busy  output  1  registered, high from the first start-bit cycle through the last stop-bit cycle

## Operation
- States: IDLE, START, DATA, PARITY, STOP (plus STOP2, see Configuration). Encoding is fixed in the shared package.
- IDLE: TX_OUT=1, busy=0. If Data_Valid=1 at an edge:
  - Capture P_DATA into the shift register.
  - Capture PAR_EN.
  - Compute the parity bit: ^P_DATA for even, ~^P_DATA for odd.
  - Go to START.
- START: TX_OUT=0 for one cycle, then DATA with the bit counter at 0.
- DATA: TX_OUT = shift register bit 0; shift right each cycle and increment the counter. After bit DATA_WIDTH-1, go to PARITY if the captured PAR_EN=1, else go to STOP.
- PARITY: TX_OUT = captured parity bit for one cycle, then STOP.
- STOP: TX_OUT=1 for one cycle, then IDLE.
- Data_Valid, P_DATA, PAR_EN and PAR_TYP are ignored while busy=1. Input changes mid-frame do not alter the frame in flight.
- Counter width is clog2(DATA_WIDTH). It never wraps past DATA_WIDTH-1 and is cleared on entry to DATA.

## Timing
- Reset (asynchronous, immediate, including mid-frame): state=IDLE, TX_OUT=1, busy=0, shift register=0, counter=0, parity bit=0. A partial frame is abandoned, and the line returns high without glitching low.
- Accept at edge k: after edge k, TX_OUT=0 (start bit) and busy=1.
- Data bit i appears after edge k+1+i.
- Frame length: 1 + DATA_WIDTH + PAR_EN + 1 cycles (11 cycles for 8 data bits with parity).
- busy falls at the edge that leaves STOP.
- Back-to-back frames: Data_Valid held high gives the next start bit one cycle after the stop bit ends. That is a minimum of one idle-high cycle between frames.
- Data_Valid=1 in the same cycle that reset deasserts is accepted only at the first rising edge with RST=1.

## Configuration
- UART_TX_STOP2_EN defined: the STOP state is followed by STOP2, a second TX_OUT=1 cycle with busy still 1. Frame length grows by 1 cycle.
- UART_TX_STOP2_EN undefined: STOP2 does not exist, and STOP returns directly to IDLE.

## Structure
- Package uart_tx_pkg holds:
  - the state enum typedef and its encoding;
  - the DATA_WIDTH default;
  - the idle, start and stop line-level constants.
- One sub-module, uart_tx_serializer, holds the shift register and bit counter. It has load, shift and done ports and is instantiated once.
- The FSM, parity capture and output mux live in uart_tx_ctrl.

## Test plan
- Reset then idle: RST low for 3 cycles -> TX_OUT=1, busy=0. Releasing RST with Data_Valid=0 keeps both unchanged.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles. busy=1 for exactly those cycles.
- P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> parity bit 0. P_DATA=0x00 with odd parity -> parity bit 1.
- P_DATA=0x3C, PAR_EN=0 -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1. Changing P_DATA to 0xFF mid-frame has no effect.
- Data_Valid held high for 25 cycles with P_DATA=0x55, PAR_EN=0 -> two frames, each followed by exactly one idle-high cycle. No request is accepted while busy=1.
- RST pulsed low during data bit 4 -> TX_OUT=1 and busy=0 immediately. The next accepted frame is complete and correct.
- With UART_TX_STOP2_EN defined, the 0xA5 even-parity case gives a 12-cycle frame ending 1,1.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller: frame state encoding,
// default data width and serial line levels.
// Optional second stop bit: define UART_TX_STOP2_EN.
package uart_tx_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
`ifdef UART_TX_STOP2_EN
        ,
        ST_STOP2  = 3'd5
`endif
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte request / serial line bundle between the TX data source (master)
// and the UART transmit controller (slave).
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for one UART frame. The controller
// reads bit_cur for the first data bit and bit_nxt while already in DATA,
// because the shift and the registered output update on the same edge.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  bit_cur,
    output logic                  bit_nxt,
    output logic                  done
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] sreg_q;
    logic [CW-1:0]         cnt_q;

    // Load the byte on accept, then shift right once per data bit; counter saturates.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            sreg_q <= data_in;
            cnt_q  <= '0;
        end else if (shift) begin
            sreg_q <= sreg_q >> 1;
            if (cnt_q != CNT_LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bit_cur = sreg_q[0];
    assign bit_nxt = sreg_q[1];
    assign done    = (cnt_q == CNT_LAST);
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte while idle and sends
// start, data (LSB first), optional parity and stop bits, one per CLK.
// Optional second stop bit: define UART_TX_STOP2_EN.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | captured parity bit
// STOP   | stop bit (high)
// STOP2  | second stop bit (only with UART_TX_STOP2_EN)
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic      CLK,
    input  logic      RST,
    uart_tx_if.slave  bus
);
    tx_state_e state_q, state_nxt;
    logic      tx_q, tx_nxt;
    logic      busy_q, busy_nxt;
    logic      par_en_q, par_bit_q;
    logic      load, shift;
    logic      bit_cur, bit_nxt, done;

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .CLK     (CLK),
        .RST     (RST),
        .load    (load),
        .shift   (shift),
        .data_in (bus.P_DATA),
        .bit_cur (bit_cur),
        .bit_nxt (bit_nxt),
        .done    (done)
    );

    // State, registered line outputs and per-frame parity settings.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            tx_q      <= LINE_IDLE;
            busy_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            tx_q    <= tx_nxt;
            busy_q  <= busy_nxt;
            if (load) begin
                par_en_q  <= bus.PAR_EN;
                par_bit_q <= bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;
            end
        end
    end

    // Next state and the line level that state will drive.
    always_comb begin
        state_nxt = state_q;
        tx_nxt    = LINE_IDLE;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Data_Valid) begin
                    state_nxt = ST_START;
                    load      = 1'b1;
                    tx_nxt    = LINE_START;
                end
            end
            ST_START: begin
                state_nxt = ST_DATA;
                tx_nxt    = bit_cur;
            end
            ST_DATA: begin
                shift = 1'b1;
                if (!done) begin
                    tx_nxt = bit_nxt;
                end else if (par_en_q) begin
                    state_nxt = ST_PARITY;
                    tx_nxt    = par_bit_q;
                end else begin
                    state_nxt = ST_STOP;
                    tx_nxt    = LINE_STOP;
                end
            end
            ST_PARITY: begin
                state_nxt = ST_STOP;
                tx_nxt    = LINE_STOP;
            end
`ifdef UART_TX_STOP2_EN
            ST_STOP: begin
                state_nxt = ST_STOP2;
                tx_nxt    = LINE_STOP;
            end
            ST_STOP2: begin
                state_nxt = ST_IDLE;
                tx_nxt    = LINE_IDLE;
            end
`else
            ST_STOP: begin
                state_nxt = ST_IDLE;
                tx_nxt    = LINE_IDLE;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = LINE_IDLE;
            end
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    assign bus.TX_OUT = tx_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: reset, framed bytes with and without
// parity, mid-frame input changes, back-to-back requests, mid-frame reset.
module tb_uart_tx_ctrl;
    localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
    localparam int XS = 1;
`else
    localparam int XS = 0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_tx_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // exp bit i is the line level i cycles after the accept edge; len counts one stop bit.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [15:0] exp, input int len,
                             input bit disturb);
        logic [15:0] e;
        int n;
        e = exp;
        n = len;
        if (XS != 0) begin
            e[n] = 1'b1;
            n    = n + 1;
        end
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Data_Valid = 1'b1;
        tick();
        bus.Data_Valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_tx%0d", tag, i), 32'(bus.TX_OUT), 32'(e[i]));
            chk($sformatf("%s_busy%0d", tag, i), 32'(bus.busy), 32'd1);
            if (disturb && i == 1) begin
                bus.P_DATA     = ~d;
                bus.PAR_EN     = ~pe;
                bus.PAR_TYP    = ~pt;
                bus.Data_Valid = 1'b1;
            end
            tick();
        end
        bus.Data_Valid = 1'b0;
        chk($sformatf("%s_idle_tx", tag), 32'(bus.TX_OUT), 32'd1);
        chk($sformatf("%s_idle_busy", tag), 32'(bus.busy), 32'd0);
    endtask

    logic [15:0] f55;
    int          per;
    int          p;

    initial begin
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;

        repeat (3) tick();
        chk("rst_tx", 32'(bus.TX_OUT), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        RST = 1'b1;
        repeat (2) tick();
        chk("rel_tx", 32'(bus.TX_OUT), 32'd1);
        chk("rel_busy", 32'(bus.busy), 32'd0);

        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 16'h054A, 11, 1'b0);
        run_frame("01_odd",  8'h01, 1'b1, 1'b1, 16'h0402, 11, 1'b0);
        run_frame("00_odd",  8'h00, 1'b1, 1'b1, 16'h0600, 11, 1'b0);
        run_frame("ff_even", 8'hFF, 1'b1, 1'b0, 16'h05FE, 11, 1'b0);
        run_frame("3c_nopar", 8'h3C, 1'b0, 1'b0, 16'h0278, 10, 1'b1);

        // Data_Valid held high: frames repeat with one idle-high cycle between them.
        f55 = 16'h02AA;
        if (XS != 0) f55[10] = 1'b1;
        per = 10 + XS + 1;
        bus.P_DATA     = 8'h55;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Data_Valid = 1'b1;
        tick();
        for (int c = 0; c < 2 * per; c++) begin
            p = c % per;
            if (p == per - 1) begin
                chk($sformatf("b2b_tx%0d", c), 32'(bus.TX_OUT), 32'd1);
                chk($sformatf("b2b_busy%0d", c), 32'(bus.busy), 32'd0);
            end else begin
                chk($sformatf("b2b_tx%0d", c), 32'(bus.TX_OUT), 32'(f55[p]));
                chk($sformatf("b2b_busy%0d", c), 32'(bus.busy), 32'd1);
            end
            if (c == 2 * per - 1) bus.Data_Valid = 1'b0;
            tick();
        end
        chk("b2b_end_tx", 32'(bus.TX_OUT), 32'd1);
        chk("b2b_end_busy", 32'(bus.busy), 32'd0);

        // Reset asserted mid-cycle during data bit 4 (a low bit of 0xA5).
        bus.P_DATA     = 8'hA5;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b0;
        bus.Data_Valid = 1'b1;
        tick();
        bus.Data_Valid = 1'b0;
        repeat (5) tick();
        chk("mid_bit4", 32'(bus.TX_OUT), 32'd0);
        #2;
        RST = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(bus.TX_OUT), 32'd1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        bus.Data_Valid = 1'b1;
        tick();
        chk("hold_rst_tx", 32'(bus.TX_OUT), 32'd1);
        chk("hold_rst_busy", 32'(bus.busy), 32'd0);
        RST = 1'b1;
        run_frame("after_rst", 8'h3C, 1'b0, 1'b0, 16'h0278, 10, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
